// File: rtl/pkt_deframer_if.sv
// Bit-stream side and frame-readout side of the packet deframer.
// The DUT connects through 'slave', the driver/readout logic through 'master'.
interface pkt_deframer_if #(
    parameter int HDR_LEN = 27,
    parameter int PAY_LEN = 32
);
    logic               sh_en;
    logic               bit_in;
    logic               fsm_rst;
    logic               rx_en;
    logic               tx_rdy;
    logic [HDR_LEN-1:0] hdr_data;
    logic [PAY_LEN-1:0] pay_data;
    logic               frame_vld;
    logic               sync_err;
    logic               overrun;
    logic               busy;

    modport slave (
        input  sh_en, bit_in, fsm_rst, rx_en, tx_rdy,
        output hdr_data, pay_data, frame_vld, sync_err, overrun, busy
    );

    modport master (
        output sh_en, bit_in, fsm_rst, rx_en, tx_rdy,
        input  hdr_data, pay_data, frame_vld, sync_err, overrun, busy
    );
endinterface

// File: rtl/pkt_deframer.sv
// Packet deframer: hunts for an all-ones preamble, captures the header,
// checks the all-ones sync field, captures the payload and holds the frame
// until the TX side accepts it. The FSM only moves on bit strobes, except
// for the HOLD exit on tx_rdy and the restart paths.
module pkt_deframer #(
    parameter int PRE_LEN  = 8,
    parameter int HDR_LEN  = 27,
    parameter int SYNC_LEN = 8,
    parameter int PAY_LEN  = 32,
    parameter int CNT_W    = 6
) (
    input  logic            i_clk,
    input  logic            i_rst,     // async, active low
    pkt_deframer_if.slave   bus
);
    typedef enum logic [2:0] {S_HUNT, S_HDR, S_SYNC, S_PAY, S_HOLD} state_t;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN  - 1);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_LEN  - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAY_LEN  - 1);

    state_t             r_state,  w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [HDR_LEN-1:0] r_hdr,    w_hdr_nxt;
    logic [PAY_LEN-1:0] r_pay,    w_pay_nxt;
    logic               r_sync_err, w_sync_err_nxt;
    logic               r_overrun,  w_overrun_nxt;
    logic               r_frame_vld;
    logic               r_busy;
    logic               w_bit_ev;

    // A strobe only counts as a bit while the receive window is open.
    assign w_bit_ev = bus.sh_en & bus.rx_en;

    // Next-state, counter and shift-register update; restart paths take priority.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hdr_nxt      = r_hdr;
        w_pay_nxt      = r_pay;
        w_sync_err_nxt = 1'b0;
        w_overrun_nxt  = 1'b0;
        if (bus.fsm_rst) begin
            w_state_nxt = S_HUNT;
            w_cnt_nxt   = '0;
        end else if (!bus.rx_en && r_state != S_HOLD) begin
            w_state_nxt = S_HUNT;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_HUNT: if (w_bit_ev) begin
                    if (!bus.bit_in)          w_cnt_nxt = '0;
                    else if (r_cnt == PRE_LAST) begin
                        w_state_nxt = S_HDR;
                        w_cnt_nxt   = '0;
                    end else                  w_cnt_nxt = r_cnt + 1'b1;
                end
                S_HDR: if (w_bit_ev) begin
                    w_hdr_nxt = {r_hdr[HDR_LEN-2:0], bus.bit_in};
                    if (r_cnt == HDR_LAST) begin
                        w_state_nxt = S_SYNC;
                        w_cnt_nxt   = '0;
                    end else                  w_cnt_nxt = r_cnt + 1'b1;
                end
                S_SYNC: if (w_bit_ev) begin
                    if (!bus.bit_in) begin
                        // header stays in the register but is stale from here on
                        w_sync_err_nxt = 1'b1;
                        w_state_nxt    = S_HUNT;
                        w_cnt_nxt      = '0;
                    end else if (r_cnt == SYNC_LAST) begin
                        w_state_nxt = S_PAY;
                        w_cnt_nxt   = '0;
                    end else                  w_cnt_nxt = r_cnt + 1'b1;
                end
                S_PAY: if (w_bit_ev) begin
                    w_pay_nxt = {r_pay[PAY_LEN-2:0], bus.bit_in};
                    if (r_cnt == PAY_LAST) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = '0;
                    end else                  w_cnt_nxt = r_cnt + 1'b1;
                end
                S_HOLD: begin
                    // a strobe here is dropped even if tx_rdy releases the frame on this edge
                    w_overrun_nxt = w_bit_ev;
                    if (bus.tx_rdy) w_state_nxt = S_HUNT;
                end
                default: begin
                    w_state_nxt = S_HUNT;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and output registers; flags are decoded from the next state so they track it exactly.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_HUNT;
            r_cnt       <= '0;
            r_hdr       <= '0;
            r_pay       <= '0;
            r_sync_err  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_vld <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hdr       <= w_hdr_nxt;
            r_pay       <= w_pay_nxt;
            r_sync_err  <= w_sync_err_nxt;
            r_overrun   <= w_overrun_nxt;
            r_frame_vld <= (w_state_nxt == S_HOLD);
            r_busy      <= (w_state_nxt == S_HDR) || (w_state_nxt == S_SYNC) ||
                           (w_state_nxt == S_PAY);
        end
    end

    assign bus.hdr_data  = r_hdr;
    assign bus.pay_data  = r_pay;
    assign bus.frame_vld = r_frame_vld;
    assign bus.sync_err  = r_sync_err;
    assign bus.overrun   = r_overrun;
    assign bus.busy      = r_busy;
endmodule
